// File: rtl/cpu_stack_unit.sv
// cpu_stack_unit: parametrised operand-stack store for the stack-machine pipeline.
//
// One write port (pop-N then optional push per cycle) and two registered read
// ports: top_0 (entry at sp-1) and top_n (entry at sp-1-peek_idx). Both read
// ports are addressed from the post-operation stack pointer, and a same-cycle
// write is forwarded so the registered outputs never show a stale RAM word.
// restore_en reloads sp from a checkpoint on a pipeline kill and drops any
// operation presented in the same cycle.
//
// Optional feature macro: CPU_STACK_BOUNDS_EN
//   defined   -> underflow/overflow checks reject bad operations and set
//                sticky flags; restores beyond DEPTH are clamped.
//   undefined -> no checks, sp wraps modulo 2**AW, flags tied to 0.

module cpu_stack_unit #(
   parameter int WIDTH      = 35,
   parameter int DEPTH_LOG2 = 11,
   parameter int POP_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   input  logic [POP_W-1:0]      pop_cnt,
   input  logic                  push_en,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  restore_en,
   input  logic [DEPTH_LOG2:0]   restore_sp,
   input  logic [DEPTH_LOG2-1:0] peek_idx,
   input  logic                  clr_err,
   output logic [DEPTH_LOG2:0]   sp,
   output logic [WIDTH-1:0]      top_0,
   output logic                  top_0_vld,
   output logic [WIDTH-1:0]      top_n,
   output logic                  top_n_vld,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int AW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   // Storage: plain array so synthesis maps it onto block RAM.
   logic [WIDTH-1:0] ram [DEPTH];

   logic [AW-1:0]         sp_reg;
   logic [AW-1:0]         sp_next;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_addr;

   // Per read port: 0 = top_0, 1 = top_n.
   logic [DEPTH_LOG2-1:0] rd_addr [2];
   logic                  rd_vld  [2];

`ifdef CPU_STACK_BOUNDS_EN
   // One extra bit so that sp - pop_cnt going negative and
   // sp - pop_cnt + push exceeding DEPTH are both visible to the checks.
   localparam int EW = AW + 1;

   logic [EW-1:0] sp_ext;
   logic [EW-1:0] pop_ext;
   logic [EW-1:0] base_ext;
   logic [EW-1:0] sum_ext;
   logic          under_hit;
   logic          over_hit;
   logic          overflow_reg;
   logic          overflow_next;
   logic          underflow_reg;
   logic          underflow_next;

   assign sp_ext   = {1'b0, sp_reg};
   assign pop_ext  = EW'(pop_cnt);
   assign base_ext = sp_ext - pop_ext;
   assign sum_ext  = base_ext + EW'(push_en);

   // Next stack pointer and write enable, with bounds checking and restore clamp.
   always_comb begin
      sp_next   = sp_reg;
      wr_en     = 1'b0;
      wr_addr   = base_ext[DEPTH_LOG2-1:0];
      under_hit = 1'b0;
      over_hit  = 1'b0;
      if (restore_en) begin
         if (restore_sp > AW'(DEPTH)) begin
            sp_next  = AW'(DEPTH);
            over_hit = 1'b1;
         end else begin
            sp_next = restore_sp;
         end
      end else if (op_valid) begin
         if (pop_ext > sp_ext) begin
            // Underflow takes precedence; overflow is not reported alongside.
            under_hit = 1'b1;
         end else if (sum_ext > EW'(DEPTH)) begin
            over_hit = 1'b1;
         end else begin
            sp_next = sum_ext[AW-1:0];
            wr_en   = push_en;
         end
      end
   end

   // Sticky error flags: clear first so a new error in the same cycle wins.
   always_comb begin
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (clr_err) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (over_hit) begin
         overflow_next = 1'b1;
      end
      if (under_hit) begin
         underflow_next = 1'b1;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`else
   logic [AW-1:0] base;
   logic [AW-1:0] sum;
   logic          unused_clr_err;

   // Unchecked arithmetic simply wraps modulo 2**AW.
   assign base = sp_reg - AW'(pop_cnt);
   assign sum  = base + AW'(push_en);

   // Next stack pointer and write enable; restore always wins over an op.
   always_comb begin
      sp_next = sp_reg;
      wr_en   = 1'b0;
      wr_addr = base[DEPTH_LOG2-1:0];
      if (restore_en) begin
         sp_next = restore_sp;
      end else if (op_valid) begin
         sp_next = sum;
         wr_en   = push_en;
      end
   end

   assign unused_clr_err = clr_err;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

   // Stack pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_reg <= '0;
      end else begin
         sp_reg <= sp_next;
      end
   end

   // RAM write port; an operation coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         ram[wr_addr] <= push_data;
      end
   end

   // Read addresses derived from the post-operation stack pointer.
   always_comb begin
      rd_addr[0] = sp_next[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
      rd_addr[1] = sp_next[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1) - peek_idx;
      rd_vld[0]  = (sp_next != '0);
      rd_vld[1]  = ({1'b0, peek_idx} < sp_next);
   end

   // Registered read ports with write forwarding; data holds while invalid.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [WIDTH-1:0] data_reg;
         logic             vld_reg;

         // Read register for this port.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_reg <= '0;
               vld_reg  <= 1'b0;
            end else begin
               vld_reg <= rd_vld[gi];
               if (rd_vld[gi]) begin
                  if (wr_en && (rd_addr[gi] == wr_addr)) begin
                     data_reg <= push_data;
                  end else begin
                     data_reg <= ram[rd_addr[gi]];
                  end
               end
            end
         end
      end
   endgenerate

   assign top_0     = g_rd[0].data_reg;
   assign top_0_vld = g_rd[0].vld_reg;
   assign top_n     = g_rd[1].data_reg;
   assign top_n_vld = g_rd[1].vld_reg;

   assign sp    = sp_reg;
   assign full  = (sp_reg == AW'(DEPTH));
   assign empty = (sp_reg == '0);

endmodule

// File: tb/tb_cpu_stack_unit.sv
// tb_cpu_stack_unit: directed plus randomised scoreboard bench for cpu_stack_unit
// with DEPTH_LOG2=3. A behavioural stack model produces the expected outputs
// for each driven cycle; they are queued and compared once the DUT registers.

module tb_cpu_stack_unit;

   localparam int WIDTH = 35;
   localparam int DL    = 3;
   localparam int POP_W = 2;
   localparam int AW    = DL + 1;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             op_valid = 1'b0;
   logic [POP_W-1:0] pop_cnt = '0;
   logic             push_en = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic             restore_en = 1'b0;
   logic [AW-1:0]    restore_sp = '0;
   logic [DL-1:0]    peek_idx = '0;
   logic             clr_err = 1'b0;
   logic [AW-1:0]    sp;
   logic [WIDTH-1:0] top_0, top_n;
   logic             top_0_vld, top_n_vld, full, empty, overflow, underflow;

   always #5 clk = ~clk;

   cpu_stack_unit #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .POP_W(POP_W)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .pop_cnt(pop_cnt),
      .push_en(push_en), .push_data(push_data), .restore_en(restore_en),
      .restore_sp(restore_sp), .peek_idx(peek_idx), .clr_err(clr_err),
      .sp(sp), .top_0(top_0), .top_0_vld(top_0_vld), .top_n(top_n),
      .top_n_vld(top_n_vld), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow)
   );

   typedef struct packed {
      logic [AW-1:0]    sp;
      logic [WIDTH-1:0] t0;
      logic             v0;
      logic [WIDTH-1:0] tn;
      logic             vn;
      logic             full;
      logic             empty;
      logic             ovf;
      logic             unf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state.
   logic [WIDTH-1:0] m_mem [DEPTH];
   int               m_sp = 0;
   logic [WIDTH-1:0] m_t0 = '0;
   logic [WIDTH-1:0] m_tn = '0;
   logic             m_v0 = 1'b0;
   logic             m_vn = 1'b0;
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model(input logic r, input logic ov, input int pc, input logic pe,
                        input logic [WIDTH-1:0] d, input logic re, input int rsp,
                        input int pk, input logic ce);
      int   nsp;
      int   pei;
      logic new_o;
      logic new_u;
      if (r) begin
         m_sp = 0; m_t0 = '0; m_tn = '0; m_v0 = 1'b0; m_vn = 1'b0;
         m_ovf = 1'b0; m_unf = 1'b0;
         return;
      end
      pei   = pe ? 1 : 0;
      nsp   = m_sp;
      new_o = 1'b0;
      new_u = 1'b0;
      if (re) begin
`ifdef CPU_STACK_BOUNDS_EN
         if (rsp > DEPTH) begin
            nsp   = DEPTH;
            new_o = 1'b1;
         end else begin
            nsp = rsp;
         end
`else
         nsp = rsp;
`endif
      end else if (ov) begin
`ifdef CPU_STACK_BOUNDS_EN
         if (pc > m_sp) begin
            new_u = 1'b1;
         end else if (m_sp - pc + pei > DEPTH) begin
            new_o = 1'b1;
         end else begin
            if (pe) m_mem[(m_sp - pc) % DEPTH] = d;
            nsp = m_sp - pc + pei;
         end
`else
         nsp = (m_sp - pc + 16) % 16;
         if (pe) m_mem[nsp % DEPTH] = d;
         nsp = (nsp + pei) % 16;
`endif
      end
      if (ce) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (new_o) m_ovf = 1'b1;
      if (new_u) m_unf = 1'b1;
      m_sp = nsp;
      m_v0 = (m_sp != 0);
      if (m_v0) m_t0 = m_mem[(m_sp - 1) % DEPTH];
      m_vn = (pk < m_sp);
      if (m_vn) m_tn = m_mem[(m_sp - 1 - pk) % DEPTH];
   endtask

   // Drive one cycle, queue the model's expectation, compare after the edge.
   task automatic step(input string tag, input logic r, input logic ov, input int pc,
                       input logic pe, input logic [WIDTH-1:0] d, input logic re,
                       input int rsp, input int pk, input logic ce);
      exp_t e;
      rst        = r;
      op_valid   = ov;
      pop_cnt    = POP_W'(pc);
      push_en    = pe;
      push_data  = d;
      restore_en = re;
      restore_sp = AW'(rsp);
      peek_idx   = DL'(pk);
      clr_err    = ce;
      model(r, ov, pc, pe, d, re, rsp, pk, ce);
      e.sp    = AW'(m_sp);
      e.t0    = m_t0;
      e.v0    = m_v0;
      e.tn    = m_tn;
      e.vn    = m_vn;
      e.full  = (m_sp == DEPTH);
      e.empty = (m_sp == 0);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".sp"},        64'(sp),        64'(e.sp));
      check({tag, ".top_0"},     64'(top_0),     64'(e.t0));
      check({tag, ".top_0_vld"}, 64'(top_0_vld), 64'(e.v0));
      check({tag, ".top_n"},     64'(top_n),     64'(e.tn));
      check({tag, ".top_n_vld"}, 64'(top_n_vld), 64'(e.vn));
      check({tag, ".full"},      64'(full),      64'(e.full));
      check({tag, ".empty"},     64'(empty),     64'(e.empty));
      check({tag, ".overflow"},  64'(overflow),  64'(e.ovf));
      check({tag, ".underflow"}, 64'(underflow), 64'(e.unf));
      $display("%-10s sp=%0d top_0=%h/%b top_n=%h/%b full=%b empty=%b ovf=%b unf=%b",
               tag, sp, top_0, top_0_vld, top_n, top_n_vld, full, empty, overflow, underflow);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

      // Reset state
      step("reset", 1, 0, 0, 0, '0, 0, 0, 0, 0);
      check("rst.sp", 64'(sp), 64'(0));
      check("rst.empty", 64'(empty), 64'(1));
      check("rst.top_0", 64'(top_0), 64'(0));

      // 1: three pushes, peek depth 2
      step("push1", 0, 1, 0, 1, 35'h1, 0, 0, 2, 0);
      step("push2", 0, 1, 0, 1, 35'h2, 0, 0, 2, 0);
      step("push3", 0, 1, 0, 1, 35'h3, 0, 0, 2, 0);
      check("t1.sp", 64'(sp), 64'(3));
      check("t1.top_0", 64'(top_0), 64'(3));
      check("t1.top_n", 64'(top_n), 64'(1));
      check("t1.vld", 64'({top_0_vld, top_n_vld}), 64'(2'b11));

      // 2: pop 2 then push 7 (replace), then peek depth 1
      step("replace", 0, 1, 2, 1, 35'h7, 0, 0, 0, 0);
      check("t2.sp", 64'(sp), 64'(2));
      check("t2.top_0", 64'(top_0), 64'(7));
      step("peek1", 0, 0, 0, 0, '0, 0, 0, 1, 0);
      check("t2.top_n", 64'(top_n), 64'(1));

      // 3: fill to DEPTH, push one more, then clear flags
      for (int i = 0; i < 6; i++) step("fill", 0, 1, 0, 1, 35'(16 + i), 0, 0, 0, 0);
      check("t3.full", 64'(full), 64'(1));
      step("push_full", 0, 1, 0, 1, 35'h9, 0, 0, 0, 0);
`ifdef CPU_STACK_BOUNDS_EN
      check("t3.sp", 64'(sp), 64'(8));
      check("t3.overflow", 64'(overflow), 64'(1));
      check("t3.top_0", 64'(top_0), 64'(35'h15));
`else
      check("t3.sp", 64'(sp), 64'(9));
      check("t3.overflow", 64'(overflow), 64'(0));
      check("t3.top_0", 64'(top_0), 64'(35'h9));
`endif
      step("clr", 0, 0, 0, 0, '0, 0, 0, 0, 1);
      check("t3.clr", 64'(overflow), 64'(0));

      // 4: pop 3 from sp=1
      step("rest1", 0, 0, 0, 0, '0, 1, 1, 0, 0);
      step("pop3", 0, 1, 3, 0, '0, 0, 0, 0, 0);
`ifdef CPU_STACK_BOUNDS_EN
      check("t4.sp", 64'(sp), 64'(1));
      check("t4.underflow", 64'(underflow), 64'(1));
`else
      check("t4.sp", 64'(sp), 64'(14));
      check("t4.underflow", 64'(underflow), 64'(0));
`endif
      step("clr", 0, 0, 0, 0, '0, 0, 0, 0, 1);

      // 5: restore beats a same-cycle push; RAM[5] must be untouched
      step("rest5", 0, 0, 0, 0, '0, 1, 5, 0, 0);
      step("rest2push", 0, 1, 0, 1, 35'hA, 1, 2, 0, 0);
      check("t5.sp", 64'(sp), 64'(2));
      check("t5.top_0", 64'(top_0), 64'(7));
      step("rest6", 0, 0, 0, 0, '0, 1, 6, 0, 0);
      check("t5.ram5", 64'(top_0), 64'(35'h13));

      // 6: reset coinciding with a push
      step("rest4", 0, 0, 0, 0, '0, 1, 4, 0, 0);
      step("rstpush", 1, 1, 0, 1, 35'hB, 0, 0, 0, 0);
      check("t6.sp", 64'(sp), 64'(0));
      check("t6.empty", 64'(empty), 64'(1));
      check("t6.top_0_vld", 64'(top_0_vld), 64'(0));
      check("t6.flags", 64'({overflow, underflow}), 64'(0));

      // Randomised back-to-back traffic against the model
      for (int i = 0; i < 150; i++) begin
         logic r, ov, pe, re, ce;
         int   pc, rsp, pk;
         logic [WIDTH-1:0] d;
         r   = ($urandom_range(0, 39) == 0);
         re  = ($urandom_range(0, 9) == 0);
         ov  = ($urandom_range(0, 3) != 0);
         pe  = ($urandom_range(0, 2) != 0);
         ce  = ($urandom_range(0, 7) == 0);
         pc  = $urandom_range(0, 3);
         rsp = $urandom_range(0, 15);
         pk  = $urandom_range(0, 7);
         d   = {$urandom, $urandom};
         step("rand", r, ov, pc, pe, d, re, rsp, pk, ce);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
